ccc_phase_shift_ctrl: RTL and testbench
=======================================

Name: ccc_phase_shift_ctrl

Overview:
Fabric-side controller for the PLL dynamic phase-shift pins of a CCC instance, generalised to NUM_OUT PLL outputs.
- Accepts phase-step requests over a valid/ready handshake.
- Sequences the select, direction, rotate and load-phase signals with programmable pulse and settle timing.
- Tracks the current phase position of every output.
- Aborts cleanly on PLL lock loss.
- Sits between the DDR/IO training logic and the CCC wrapper.

Parameters:
NUM_OUT, 4, number of PLL outputs with phase-select pins (1..4)
STEP_W, 6, width of the requested step count (max 2^STEP_W-1 steps per request)
POS_W, 3, width of the per-output phase position counter; wraps modulo 2^POS_W
PULSE_HIGH, 2, cycles PHASE_ROTATE_0 is held high per step (>=1)
SETTLE_CYCLES, 8, cycles PHASE_ROTATE_0 is held low after each pulse (>=1)

Ports:
CLK  in  1  single clock for the whole block
RESET  in  1  synchronous, active-high reset
PLL_LOCK_0  in  1  PLL lock, asynchronous to CLK
REQ_VALID  in  1  request valid
REQ_READY  out  1  controller can accept a request
REQ_OUT_MASK  in  NUM_OUT  outputs to shift
REQ_DIR  in  1  1 = advance phase (position +1 per step), 0 = retard (position -1 per step)
REQ_STEPS  in  STEP_W  number of rotate steps
PHASE_OUT_SEL_0  out  NUM_OUT  to PLL PHASE_OUTx_SEL pins
PHASE_DIRECTION_0  out  1  to PLL PHASE_DIRECTION
PHASE_ROTATE_0  out  1  to PLL PHASE_ROTATE
LOAD_PHASE_N_0  out  1  to PLL LOAD_PHASE_N, active low
PHASE_POS  out  NUM_OUT*POS_W  current position per output; output i occupies bits [i*POS_W +: POS_W]
DONE_STB  out  1  one-cycle pulse when a request completes
ERR_STB  out  1  one-cycle pulse when a request is aborted by lock loss
LOCKED  out  1  synchronised lock

Behaviour:
- Reset values: REQ_READY=0, PHASE_OUT_SEL_0=0, PHASE_DIRECTION_0=0, PHASE_ROTATE_0=0, LOAD_PHASE_N_0=1, PHASE_POS=0, DONE_STB=0, ERR_STB=0, LOCKED=0. The FSM resets to IDLE.
- Lock synchronisation: PLL_LOCK_0 passes through a 2-flop synchroniser to LOCKED, so LOCKED follows the pin 2 cycles later.
- On each LOCKED rising edge, all PHASE_POS counters clear to 0, because the PLL relocks at default phase.
- All outputs are registered.
- FSM states: IDLE, SETUP, ROT_HI, ROT_LO, LOAD.
- IDLE:
  - REQ_READY = LOCKED.
  - Accept occurs on REQ_VALID & REQ_READY at cycle T; mask, direction and step count are captured at T.
  - If the request has REQ_STEPS==0 or REQ_OUT_MASK==0: stay in IDLE, no pins toggle, DONE_STB=1 at T+1, REQ_READY=1 at T+1.
  - Otherwise go to SETUP.
- SETUP (1 cycle, T+1): drive PHASE_OUT_SEL_0=mask and PHASE_DIRECTION_0=dir. Both are held stable until LOAD ends.
- ROT_HI (PULSE_HIGH cycles): PHASE_ROTATE_0=1.
- ROT_LO (SETTLE_CYCLES cycles): PHASE_ROTATE_0=0.
  - On entry, each masked channel's PHASE_POS moves ±1 modulo 2^POS_W (7+1→0, 0-1→7 at POS_W=3).
  - At the end, the remaining-step counter decrements. If nonzero go to ROT_HI, else go to LOAD.
- LOAD (1 cycle): LOAD_PHASE_N_0=0. Then go to IDLE with PHASE_OUT_SEL_0=0 and DONE_STB=1.
- Completion timing for S steps: DONE_STB at cycle T+3+S*(PULSE_HIGH+SETTLE_CYCLES). REQ_READY is high that same cycle, so back-to-back accept is allowed then.
- Lock loss (LOCKED=0) in any non-IDLE state:
  - Next cycle: FSM goes to IDLE, PHASE_ROTATE_0=0, PHASE_OUT_SEL_0=0, LOAD_PHASE_N_0=1, ERR_STB=1, no DONE_STB.
  - The remaining steps are discarded. PHASE_POS keeps its partial values until the next LOCKED rise.
- REQ_VALID with LOCKED=0 is never accepted. The requester holds VALID, and no request is dropped.
- RESET mid-operation: all outputs return to reset values on the next edge, with no LOAD pulse.
- DONE_STB and ERR_STB are never high in the same cycle.

Decomposition:
- Package ccc_phase_pkg holds:
  - the FSM state enum;
  - constants DIR_ADVANCE=1 and DIR_RETARD=0;
  - a function for the per-request latency 3+S*(PULSE_HIGH+SETTLE_CYCLES), shared with the bench.
- Sub-module ccc_lock_sync: the 2-flop synchroniser plus rising-edge detect, reused by other CCC controllers.

Test Plan:
- Reset, then PLL_LOCK_0=1 at cycle 0 → LOCKED=1 and REQ_READY=1 at cycle 2; all pins at their reset values.
- Request mask=4'b0101, dir=1, steps=3 at T (defaults) → PHASE_ROTATE_0 high at T+2..T+3, T+12..T+13, T+22..T+23; LOAD_PHASE_N_0 low at T+32; DONE_STB at T+33; PHASE_POS ch0=ch2=3, ch1=ch3=0.
- From ch0 position 0, request dir=0, steps=2, mask=4'b0001 → PHASE_POS ch0=6 (wrap), PHASE_DIRECTION_0=0 throughout, LOAD pulse once.
- Request steps=0 or mask=0 → DONE_STB at T+1, no PHASE_ROTATE_0/LOAD_PHASE_N_0 activity, PHASE_POS unchanged.
- Steps=5, PLL_LOCK_0 dropped at T+15 → ERR_STB once at T+18, no DONE_STB, pins idle, REQ_READY stays 0 until relock; on relock PHASE_POS=0.
- RESET asserted at T+5 of a 4-step request → next cycle all outputs at reset values; no LOAD pulse; REQ_READY returns 2 cycles after RESET releases with lock high.

Source files
------------

// File: rtl/ccc_phase_pkg.sv
// rtl/ccc_phase_pkg.sv - shared state type, direction codes and latency helper for the CCC phase-shift controller
package ccc_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ROT_HI,
        ROT_LO,
        LOAD
    } phase_state_e;

    localparam logic DIR_ADVANCE = 1'b1;
    localparam logic DIR_RETARD  = 1'b0;

    // Accept-to-DONE_STB distance for a request that actually rotates (steps > 0, mask != 0).
    function automatic int unsigned req_latency(input int unsigned steps,
                                                input int unsigned pulse_high,
                                                input int unsigned settle_cycles);
        return 3 + steps * (pulse_high + settle_cycles);
    endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// rtl/ccc_lock_sync.sv - two-flop synchroniser with rising-edge detect for PLL lock
module ccc_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic sync_next,
    output logic rise
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    // sync_next/rise describe what sync_out becomes on the coming edge, so
    // consumers can register side effects in step with the synchronised level.
    assign sync_out  = sync_q;
    assign sync_next = meta_q;
    assign rise      = meta_q & ~sync_q;

endmodule

// File: rtl/ccc_phase_shift_ctrl.sv
// rtl/ccc_phase_shift_ctrl.sv - sequences PLL dynamic phase-shift pins and tracks per-output phase position
module ccc_phase_shift_ctrl
    import ccc_phase_pkg::*;
#(
    parameter int NUM_OUT       = 4,
    parameter int STEP_W        = 6,
    parameter int POS_W         = 3,
    parameter int PULSE_HIGH    = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     PLL_LOCK_0,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [NUM_OUT-1:0]       REQ_OUT_MASK,
    input  logic                     REQ_DIR,
    input  logic [STEP_W-1:0]        REQ_STEPS,
    output logic [NUM_OUT-1:0]       PHASE_OUT_SEL_0,
    output logic                     PHASE_DIRECTION_0,
    output logic                     PHASE_ROTATE_0,
    output logic                     LOAD_PHASE_N_0,
    output logic [NUM_OUT*POS_W-1:0] PHASE_POS,
    output logic                     DONE_STB,
    output logic                     ERR_STB,
    output logic                     LOCKED
);

    localparam int TMR_MAX = (PULSE_HIGH > SETTLE_CYCLES) ? PULSE_HIGH : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HI_RELOAD = TMR_W'(PULSE_HIGH - 1);
    localparam logic [TMR_W-1:0] LO_RELOAD = TMR_W'(SETTLE_CYCLES - 1);

    logic lock_next;
    logic lock_rise;

    ccc_lock_sync u_lock_sync (
        .clk       (CLK),
        .reset     (RESET),
        .async_in  (PLL_LOCK_0),
        .sync_out  (LOCKED),
        .sync_next (lock_next),
        .rise      (lock_rise)
    );

    phase_state_e             state_q, state_d;
    logic [NUM_OUT-1:0]       mask_q, mask_d;
    logic                     dir_q, dir_d;
    logic [STEP_W-1:0]        steps_q, steps_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [NUM_OUT*POS_W-1:0] pos_d;
    logic [NUM_OUT-1:0]       sel_d;
    logic                     busy_d, dir_out_d, rot_d, load_n_d, done_d, err_d, ready_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q           <= IDLE;
            mask_q            <= '0;
            dir_q             <= 1'b0;
            steps_q           <= '0;
            tmr_q             <= '0;
            PHASE_POS         <= '0;
            PHASE_OUT_SEL_0   <= '0;
            PHASE_DIRECTION_0 <= 1'b0;
            PHASE_ROTATE_0    <= 1'b0;
            LOAD_PHASE_N_0    <= 1'b1;
            DONE_STB          <= 1'b0;
            ERR_STB           <= 1'b0;
            REQ_READY         <= 1'b0;
        end else begin
            state_q           <= state_d;
            mask_q            <= mask_d;
            dir_q             <= dir_d;
            steps_q           <= steps_d;
            tmr_q             <= tmr_d;
            PHASE_POS         <= pos_d;
            PHASE_OUT_SEL_0   <= sel_d;
            PHASE_DIRECTION_0 <= dir_out_d;
            PHASE_ROTATE_0    <= rot_d;
            LOAD_PHASE_N_0    <= load_n_d;
            DONE_STB          <= done_d;
            ERR_STB           <= err_d;
            REQ_READY         <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        tmr_d   = tmr_q;
        pos_d   = PHASE_POS;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (state_q != IDLE && !LOCKED) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        mask_d  = REQ_OUT_MASK;
                        dir_d   = REQ_DIR;
                        steps_d = REQ_STEPS;
                        if (REQ_STEPS == '0 || REQ_OUT_MASK == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = SETUP;
                        end
                    end
                end
                SETUP: begin
                    state_d = ROT_HI;
                    tmr_d   = HI_RELOAD;
                end
                ROT_HI: begin
                    if (tmr_q == '0) begin
                        state_d = ROT_LO;
                        tmr_d   = LO_RELOAD;
                        // Position moves as the pulse ends, so PHASE_POS is valid through the settle window.
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (mask_q[i]) begin
                                pos_d[i*POS_W +: POS_W] = (dir_q == DIR_ADVANCE)
                                    ? PHASE_POS[i*POS_W +: POS_W] + POS_W'(1)
                                    : PHASE_POS[i*POS_W +: POS_W] - POS_W'(1);
                            end
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ROT_LO: begin
                    if (tmr_q == '0) begin
                        steps_d = steps_q - STEP_W'(1);
                        if (steps_q == STEP_W'(1)) begin
                            state_d = LOAD;
                        end else begin
                            state_d = ROT_HI;
                            tmr_d   = HI_RELOAD;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                LOAD: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // The PLL comes back at its default phase after relocking.
        if (lock_rise) begin
            pos_d = '0;
        end

        busy_d    = (state_d != IDLE);
        sel_d     = busy_d ? mask_d : '0;
        dir_out_d = busy_d ? dir_d : 1'b0;
        rot_d     = (state_d == ROT_HI);
        load_n_d  = (state_d != LOAD);
        ready_d   = !busy_d && lock_next;
    end

endmodule

// File: tb/tb_ccc_phase_shift_ctrl.sv
// tb/tb_ccc_phase_shift_ctrl.sv - self-checking bench for ccc_phase_shift_ctrl
module tb_ccc_phase_shift_ctrl;
    import ccc_phase_pkg::*;

    localparam int NUM_OUT = 4;
    localparam int STEP_W  = 6;
    localparam int POS_W   = 3;
    localparam int PH      = 2;
    localparam int SC      = 8;
    localparam int PER     = PH + SC;

    logic                     CLK = 1'b0;
    logic                     RESET;
    logic                     PLL_LOCK_0;
    logic                     REQ_VALID;
    logic                     REQ_READY;
    logic [NUM_OUT-1:0]       REQ_OUT_MASK;
    logic                     REQ_DIR;
    logic [STEP_W-1:0]        REQ_STEPS;
    logic [NUM_OUT-1:0]       PHASE_OUT_SEL_0;
    logic                     PHASE_DIRECTION_0;
    logic                     PHASE_ROTATE_0;
    logic                     LOAD_PHASE_N_0;
    logic [NUM_OUT*POS_W-1:0] PHASE_POS;
    logic                     DONE_STB;
    logic                     ERR_STB;
    logic                     LOCKED;

    ccc_phase_shift_ctrl #(
        .NUM_OUT(NUM_OUT), .STEP_W(STEP_W), .POS_W(POS_W),
        .PULSE_HIGH(PH), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PLL_LOCK_0(PLL_LOCK_0),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OUT_MASK(REQ_OUT_MASK), .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .PHASE_OUT_SEL_0(PHASE_OUT_SEL_0), .PHASE_DIRECTION_0(PHASE_DIRECTION_0),
        .PHASE_ROTATE_0(PHASE_ROTATE_0), .LOAD_PHASE_N_0(LOAD_PHASE_N_0),
        .PHASE_POS(PHASE_POS), .DONE_STB(DONE_STB), .ERR_STB(ERR_STB), .LOCKED(LOCKED)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int pos_m[NUM_OUT];

    typedef struct {
        logic [3:0]  mask;
        logic        dir;
        int          steps;
        logic [11:0] exp_pos;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] pos_pack();
        logic [11:0] p;
        for (int i = 0; i < NUM_OUT; i++) p[i*POS_W +: POS_W] = 3'(pos_m[i]);
        return p;
    endfunction

    task automatic model_apply(input logic [3:0] mask, input logic dir, input int steps);
        for (int i = 0; i < NUM_OUT; i++)
            if (mask[i]) pos_m[i] = (((pos_m[i] + (dir ? steps : -steps)) % 8) + 8) % 8;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_OUT; i++) pos_m[i] = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " ready_before_accept"}, REQ_READY, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ready"},  REQ_READY, 0);
        check({tag, " sel"},    PHASE_OUT_SEL_0, 0);
        check({tag, " dir"},    PHASE_DIRECTION_0, 0);
        check({tag, " rot"},    PHASE_ROTATE_0, 0);
        check({tag, " load_n"}, LOAD_PHASE_N_0, 1);
        check({tag, " pos"},    PHASE_POS, 0);
        check({tag, " done"},   DONE_STB, 0);
        check({tag, " err"},    ERR_STB, 0);
        check({tag, " locked"}, LOCKED, 0);
    endtask

    // Issues one request and watches every cycle until DONE_STB against a timeline
    // derived from pulse/settle arithmetic: offset k is cycles after the accept cycle.
    task automatic run_req(input logic [3:0] mask, input logic dir, input int steps,
                           input logic [11:0] exp_pos, input int exp_lat, input string tag);
        int done_at, pin_bad, err_n, win_end;
        bit active, in_win, exp_rot, exp_load;
        active  = (steps != 0) && (mask != 0);
        win_end = 2 + steps * PER;
        wait_ready(tag);
        REQ_VALID = 1'b1; REQ_OUT_MASK = mask; REQ_DIR = dir; REQ_STEPS = STEP_W'(steps);
        tick();
        REQ_VALID = 1'b0;
        done_at = -1; pin_bad = 0; err_n = 0;
        for (int k = 1; k <= 200; k++) begin
            in_win   = active && k <= win_end;
            exp_rot  = in_win && k >= 2 && k < win_end && ((k - 2) % PER) < PH;
            exp_load = in_win && k == win_end;
            if (PHASE_ROTATE_0 !== exp_rot) pin_bad++;
            if (LOAD_PHASE_N_0 !== !exp_load) pin_bad++;
            if (PHASE_OUT_SEL_0 !== (in_win ? mask : 4'b0000)) pin_bad++;
            if (in_win && PHASE_DIRECTION_0 !== dir) pin_bad++;
            if (ERR_STB) err_n++;
            if (DONE_STB) begin
                done_at = k;
                break;
            end
            tick();
        end
        check({tag, " done_latency"}, done_at, exp_lat);
        check({tag, " pin_timeline_errors"}, pin_bad, 0);
        check({tag, " err_pulses"}, err_n, 0);
        check({tag, " phase_pos"}, PHASE_POS, exp_pos);
        check({tag, " ready_at_done"}, REQ_READY, 1);
    endtask

    initial begin
        logic [3:0] m;
        logic       d;
        int         s, lat, err_at, err_n, done_n, idle_bad, load_n_low;

        vecs[0] = '{4'b0101, DIR_ADVANCE, 3, 12'h0C3, 33};
        vecs[1] = '{4'b0001, DIR_RETARD,  3, 12'h0C0, 33};
        vecs[2] = '{4'b0001, DIR_RETARD,  2, 12'h0C6, 23};
        vecs[3] = '{4'b0000, DIR_ADVANCE, 5, 12'h0C6, 1};
        vecs[4] = '{4'b1111, DIR_ADVANCE, 0, 12'h0C6, 1};
        vecs[5] = '{4'b1010, DIR_RETARD,  1, 12'hEFE, 13};

        RESET = 1'b1; PLL_LOCK_0 = 1'b0; REQ_VALID = 1'b0;
        REQ_OUT_MASK = '0; REQ_DIR = 1'b0; REQ_STEPS = '0;
        model_clear();
        repeat (3) tick();
        check_reset_vals("reset");

        RESET = 1'b0; PLL_LOCK_0 = 1'b1;
        tick();
        check("lock c1 locked", LOCKED, 0);
        check("lock c1 ready", REQ_READY, 0);
        tick();
        check("lock c2 locked", LOCKED, 1);
        check("lock c2 ready", REQ_READY, 1);
        check("lock c2 load_n", LOAD_PHASE_N_0, 1);
        check("lock c2 pos", PHASE_POS, 0);

        for (int v = 0; v < 6; v++) begin
            model_apply(vecs[v].mask, vecs[v].dir, vecs[v].steps);
            run_req(vecs[v].mask, vecs[v].dir, vecs[v].steps, vecs[v].exp_pos, vecs[v].exp_lat,
                    $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 12; r++) begin
            m = 4'($urandom_range(0, 15));
            d = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 6));
            lat = (s == 0 || m == 0) ? 1 : int'(req_latency(s, PH, SC));
            model_apply(m, d, s);
            run_req(m, d, s, pos_pack(), lat, $sformatf("rand%0d", r));
        end

        // Lock loss in the middle of a 5-step request.
        wait_ready("abort");
        REQ_VALID = 1'b1; REQ_OUT_MASK = 4'b0011; REQ_DIR = DIR_ADVANCE; REQ_STEPS = 6'd5;
        tick();
        REQ_VALID = 1'b0;
        model_apply(4'b0011, DIR_ADVANCE, 2);
        err_at = -1; err_n = 0; done_n = 0; idle_bad = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 15) PLL_LOCK_0 = 1'b0;
            if (k == 20) begin
                REQ_VALID = 1'b1; REQ_OUT_MASK = 4'b0001; REQ_DIR = DIR_ADVANCE; REQ_STEPS = 6'd1;
            end
            if (ERR_STB) begin
                err_n++;
                if (err_at < 0) err_at = k;
            end
            if (DONE_STB) done_n++;
            if (k >= 18 && (PHASE_ROTATE_0 || PHASE_OUT_SEL_0 != 0 || !LOAD_PHASE_N_0 || REQ_READY))
                idle_bad++;
            if (k < 30) tick();
        end
        check("abort err_cycle", err_at, 18);
        check("abort err_pulses", err_n, 1);
        check("abort done_pulses", done_n, 0);
        check("abort idle_pin_errors", idle_bad, 0);
        check("abort partial_pos", PHASE_POS, pos_pack());
        check("abort locked", LOCKED, 0);

        PLL_LOCK_0 = 1'b1;
        tick();
        check("relock c1 locked", LOCKED, 0);
        check("relock c1 ready", REQ_READY, 0);
        tick();
        check("relock c2 locked", LOCKED, 1);
        check("relock c2 ready", REQ_READY, 1);
        check("relock c2 pos", PHASE_POS, 0);
        model_clear();
        model_apply(4'b0001, DIR_ADVANCE, 1);
        run_req(4'b0001, DIR_ADVANCE, 1, pos_pack(), 13, "held_req");

        // Reset in the settle window of a 4-step request.
        wait_ready("rst_mid");
        REQ_VALID = 1'b1; REQ_OUT_MASK = 4'b1111; REQ_DIR = DIR_ADVANCE; REQ_STEPS = 6'd4;
        tick();
        REQ_VALID = 1'b0;
        load_n_low = 0;
        for (int k = 1; k < 5; k++) begin
            if (!LOAD_PHASE_N_0) load_n_low++;
            tick();
        end
        RESET = 1'b1;
        tick();
        check_reset_vals("rst_mid");
        for (int k = 0; k < 3; k++) begin
            if (!LOAD_PHASE_N_0) load_n_low++;
            tick();
        end
        RESET = 1'b0;
        tick();
        if (!LOAD_PHASE_N_0) load_n_low++;
        check("rst_release c1 ready", REQ_READY, 0);
        tick();
        check("rst_release c2 ready", REQ_READY, 1);
        check("rst_release c2 locked", LOCKED, 1);
        check("rst_mid load_pulses", load_n_low, 0);
        model_clear();
        model_apply(4'b0100, DIR_RETARD, 1);
        run_req(4'b0100, DIR_RETARD, 1, pos_pack(), 13, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
